// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory for the load/store stage.
// Latency: writes commit on the rising clk edge; reads are combinational, zero cycles.
// Backpressure: none; a read and a write can both be issued every cycle, and rst only blocks writes.
module data_memory #(
  parameter int ADDRW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       funct3,
  input  logic [ADDRW-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int DEPTH = 1 << ADDRW;

  // Access length codes carried in funct3[1:0]. The reserved code 2'b11 is handled as a word.
  localparam logic [1:0] ML_BYTE = 2'b00;
  localparam logic [1:0] ML_HALF = 2'b01;
  localparam logic [1:0] ML_WORD = 2'b10;

  // The byte array is cleared at power-up only. Reset never clears it, so it has an initialiser and not a reset branch.
  logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

  // Per-lane byte address, write enable, write data and read data.
  // Lane k is the byte at addr+k. The address wraps modulo DEPTH, which lets misaligned accesses
  // at the top of memory continue at byte 0.
  logic [ADDRW-1:0] lane_addr [4];
  logic [3:0]       lane_en;
  logic [7:0]       lane_wr_d [4];
  logic [7:0]       lane_rd   [4];
  logic             sext;

  // Build the lane addresses and data, and set the lane mask from the access length.
  always_comb begin
    lane_en = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      lane_addr[k] = addr + ADDRW'(k);
      lane_wr_d[k] = wdata[8*k +: 8];
      lane_rd[k]   = mem_q[lane_addr[k]];
    end
    case (funct3[1:0])
      ML_BYTE: lane_en = 4'b0001;
      ML_HALF: lane_en = 4'b0011;
      ML_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b1111;
    endcase
  end

  // Commit the enabled store lanes. A cycle with rst high drops the write, and the contents are left as they are.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) begin
          mem_q[lane_addr[k]] <= lane_wr_d[k];
        end
      end
    end
  end

  // Build the load result and extend it. funct3[2] set means a zero-extended (unsigned) load.
  always_comb begin
    sext  = ~funct3[2];
    rdata = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
    case (funct3[1:0])
      ML_BYTE: rdata = {{24{sext & lane_rd[0][7]}}, lane_rd[0]};
      ML_HALF: rdata = {{16{sext & lane_rd[1][7]}}, lane_rd[1], lane_rd[0]};
      default: rdata = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
    endcase
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed cases plus random loads and stores.
// Every issued cycle pushes its expected rdata into a queue, and a negedge monitor pops and compares.
// The reference model is a plain byte array with arithmetic sign extension.
module tb_data_memory;

  localparam int ADDRW = 10;
  localparam int DEPTH = 1 << ADDRW;

  logic             clk;
  logic             rst;
  logic             we;
  logic [2:0]       funct3;
  logic [ADDRW-1:0] addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;

  data_memory #(.ADDRW(ADDRW)) dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  logic       chk_vld;
  int         assert_cnt;
  int         fail_cnt;
  logic [7:0] ref_mem [DEPTH];

  function automatic int len_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input int a, input logic [2:0] f3);
    int     n;
    longint v;
    n = len_bytes(f3);
    v = 0;
    for (int i = 0; i < n; i++)
      v = v + (longint'(ref_mem[(a + i) % DEPTH]) << (8 * i));
    if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_write(input int a, input logic [2:0] f3, input logic [31:0] wd);
    int n;
    n = len_bytes(f3);
    for (int i = 0; i < n; i++)
      ref_mem[(a + i) % DEPTH] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  // Drive one cycle. Call it just after a rising edge.
  // The expected read value reflects the contents before this cycle's edge.
  task automatic cycle(input logic w, input logic r, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, input logic use_exp, input logic [31:0] exp,
                       input string nm);
    exp_t e;
    rst    = r;
    we     = w;
    funct3 = f3;
    addr   = ADDRW'(a);
    wdata  = wd;
    e.nm   = nm;
    e.exp  = use_exp ? exp : model_read(a, f3);
    sb_q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk);
    #1;
    if (w && !r) model_write(a, f3, wd);
  endtask

  task automatic wr(input logic [2:0] f3, input int a, input logic [31:0] wd, input string nm);
    cycle(1'b1, 1'b0, f3, a, wd, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [2:0] f3, input int a, input logic [31:0] exp, input string nm);
    cycle(1'b0, 1'b0, f3, a, 32'h0, 1'b1, exp, nm);
  endtask

  // Monitor: while stimulus marks a cycle valid, compare rdata at the negedge against the oldest expectation.
  always @(negedge clk) begin
    if (chk_vld) begin
      assert_cnt++;
      if (sb_q.size() == 0) begin
        fail_cnt++;
        $display("FAIL scoreboard_empty: rdata=%08h with no expected entry", rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (rdata !== e.exp) begin
          fail_cnt++;
          $display("FAIL %s: addr=%0d funct3=%03b rdata=%08h expected=%08h",
                   e.nm, addr, funct3, rdata, e.exp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget, failures=%0d", fail_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] wd;
    int          a;
    logic        w;
    logic        r;
    assert_cnt = 0;
    fail_cnt   = 0;
    chk_vld    = 1'b0;
    rst        = 1'b1;
    we         = 1'b0;
    funct3     = 3'b010;
    addr       = '0;
    wdata      = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    #1;

    // Reset state: the memory starts cleared, and rdata follows the contents during reset
    cycle(1'b0, 1'b1, 3'b010, 0,    32'h0, 1'b1, 32'h0, "reset_word0");
    cycle(1'b0, 1'b1, 3'b010, 1020, 32'h0, 1'b1, 32'h0, "reset_word1020");

    // Store a word, then a byte, then read across them
    wr(3'b010, 0, 32'hA74D2F93, "wr_word0");
    wr(3'b000, 5, 32'h12345686, "wr_byte5");
    rd(3'b010, 5, 32'h00000086, "rd_word5");
    // Byte loads, unsigned and signed
    rd(3'b100, 0, 32'h00000093, "rd_lbu0");
    rd(3'b000, 0, 32'hFFFFFF93, "rd_lb0");
    // Half and word loads
    rd(3'b001, 0, 32'h00002F93, "rd_lh0");
    rd(3'b010, 0, 32'hA74D2F93, "rd_lw0");
    rd(3'b110, 0, 32'hA74D2F93, "rd_lw0_flag_ignored");
    rd(3'b011, 0, 32'hA74D2F93, "rd_len11_as_word");
    // Half store, with the neighbouring bytes left unchanged
    wr(3'b101, 2, 32'hFFFF8001, "wr_half2");
    rd(3'b001, 2, 32'hFFFF8001, "rd_lh2");
    rd(3'b101, 2, 32'h00008001, "rd_lhu2");
    rd(3'b010, 0, 32'h80012F93, "rd_word0_after_half");
    // Misaligned word that wraps past the top of memory
    wr(3'b010, 1023, 32'h11223344, "wr_word1023");
    rd(3'b100, 1023, 32'h00000044, "rd_byte1023");
    rd(3'b100, 0,    32'h00000033, "rd_byte0_wrap");
    rd(3'b010, 1023, 32'h11223344, "rd_word1023");
    rd(3'b001, 1,    32'h00001122, "rd_half1_wrap");
    // A write issued with reset high is dropped; writes resume once reset is low
    cycle(1'b1, 1'b1, 3'b010, 0, 32'hDEADBEEF, 1'b0, 32'h0, "rst_wr_cycle");
    rd(3'b010, 0, 32'h80112233, "rd_word0_after_rst_wr");
    wr(3'b010, 0, 32'hDEADBEEF, "wr_word0_post_rst");
    rd(3'b010, 0, 32'hDEADBEEF, "rd_word0_post_rst");

    // Random loads and stores, including resets, misaligned accesses and the wrap region
    for (int i = 0; i < 1500; i++) begin
      f3 = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) a = DEPTH - 4 + $urandom_range(0, 7);
      else                            a = $urandom_range(0, 63);
      a = a % DEPTH;
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 9) == 0);
      cycle(w, r, f3, a, wd, 1'b0, 32'h0, r ? "rand_rst" : (w ? "rand_wr" : "rand_rd"));
    end

    chk_vld = 1'b0;
    we      = 1'b0;
    @(negedge clk);
    assert_cnt++;
    if (sb_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
